fifo_shift_ram_monitor: RTL and testbench

Parametrised, synthesizable protocol monitor for the multi-level shift-RAM FIFO. It sits beside the RAM controller and checks each level's address window and write mutual exclusion. It also detects read/write address collisions and tracks per-level occupancy to flag overflow and underflow. Errors are reported as registered pulses, sticky flags, a saturating count and a first-error capture record readable by the bench or a status register block.

---
 rtl/fifo_mon_pkg.sv | 32 +++
 rtl/fifo_mon_level.sv | 63 ++++++
 rtl/fifo_shift_ram_monitor.sv | 147 ++++++++++++++
 tb/tb_fifo_shift_ram_monitor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fifo_mon_pkg.sv
// Shared types and constants for the shift-RAM FIFO protocol monitor.
package fifo_mon_pkg;

   localparam int ERR_W = 7;

   // Error code doubles as the bit index into err_pulse / err_sticky.
   typedef enum logic [2:0] {
      MUTEX    = 3'd0,
      WR_RANGE = 3'd1,
      RD_RANGE = 3'd2,
      RD_SEL   = 3'd3,
      COLLIDE  = 3'd4,
      OVF      = 3'd5,
      UNF      = 3'd6
   } err_code_e;

   // Default 11-level address windows, level 0 in the LSBs.
   localparam logic [120:0] LEVEL_MIN_DEFAULT = {
      11'd1536, 11'd1280, 11'd1024, 11'd768, 11'd640, 11'd512,
      11'd384,  11'd256,  11'd128,  11'd64,  11'd0
   };
   localparam logic [120:0] LEVEL_MAX_DEFAULT = {
      11'd1722, 11'd1449, 11'd1176, 11'd903, 11'd758, 11'd613,
      11'd468,  11'd323,  11'd178,  11'd97,  11'd16
   };

   // Number of entries a level can hold (inclusive window).
   function automatic logic [15:0] level_capacity(input logic [15:0] lo, input logic [15:0] hi);
      return hi - lo + 16'd1;
   endfunction

endpackage

// File: rtl/fifo_mon_level.sv
// Per-level window check and occupancy tracking for the FIFO monitor.
module fifo_mon_level
   import fifo_mon_pkg::*;
#(
   parameter int                ADDR_W  = 11,
   parameter int                OCC_W   = 8,
   parameter logic [ADDR_W-1:0] LVL_MIN = '0,
   parameter logic [ADDR_W-1:0] LVL_MAX = '0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_i,
   input  logic              rd_i,
   input  logic [ADDR_W-1:0] addra_i,
   input  logic [ADDR_W-1:0] addrb_i,
   output logic              wr_oor_o,
   output logic              rd_oor_o,
   output logic              ovf_o,
   output logic              unf_o,
   output logic [OCC_W-1:0]  occ_o
);

   localparam logic [OCC_W-1:0] CAP = OCC_W'(level_capacity(16'(LVL_MIN), 16'(LVL_MAX)));

   logic [ADDR_W:0]  wr_lo_s, wr_hi_s, rd_lo_s, rd_hi_s;
   logic [OCC_W-1:0] occ_d, occ_q;

   // Window compare via subtraction borrow; avoids constant-compare warnings when a bound is 0.
   always_comb begin
      wr_lo_s  = {1'b0, addra_i} - {1'b0, LVL_MIN};
      wr_hi_s  = {1'b0, LVL_MAX} - {1'b0, addra_i};
      rd_lo_s  = {1'b0, addrb_i} - {1'b0, LVL_MIN};
      rd_hi_s  = {1'b0, LVL_MAX} - {1'b0, addrb_i};
      wr_oor_o = wr_i & (wr_lo_s[ADDR_W] | wr_hi_s[ADDR_W]);
      rd_oor_o = rd_i & (rd_lo_s[ADDR_W] | rd_hi_s[ADDR_W]);
      ovf_o    = wr_i & ~rd_i & (occ_q == CAP);
      unf_o    = rd_i & ~wr_i & (occ_q == {OCC_W{1'b0}});
   end

   // Occupancy next state: +1 on lone write, -1 on lone read, hold when saturating.
   always_comb begin
      occ_d = occ_q;
      if (wr_i && !rd_i && !ovf_o) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (rd_i && !wr_i && !unf_o) begin
         occ_d = occ_q - OCC_W'(1);
      end else begin
         occ_d = occ_q;
      end
   end

   // Occupancy register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         occ_q <= {OCC_W{1'b0}};
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occ_o = occ_q;

endmodule

// File: rtl/fifo_shift_ram_monitor.sv
// Protocol monitor for the multi-level shift-RAM FIFO: detection, priority encode, error records.
module fifo_shift_ram_monitor
   import fifo_mon_pkg::*;
#(
   parameter int                             NUM_LEVELS = 11,
   parameter int                             ADDR_W     = 11,
   parameter int                             SEL_W      = 4,
   parameter int                             OCC_W      = 8,
   parameter logic [NUM_LEVELS*ADDR_W-1:0]   LEVEL_MIN  = LEVEL_MIN_DEFAULT,
   parameter logic [NUM_LEVELS*ADDR_W-1:0]   LEVEL_MAX  = LEVEL_MAX_DEFAULT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          clear,
   input  logic                          ram_we,
   input  logic                          ram_re,
   input  logic [NUM_LEVELS-1:0]         push,
   input  logic [ADDR_W-1:0]             addra,
   input  logic [ADDR_W-1:0]             addrb,
   input  logic [SEL_W-1:0]              sel,
   output logic [ERR_W-1:0]              err_pulse,
   output logic [ERR_W-1:0]              err_sticky,
   output logic [15:0]                   err_count,
   output logic                          first_valid,
   output logic [2:0]                    first_code,
   output logic [3:0]                    first_level,
   output logic [ADDR_W-1:0]             first_addr,
   output logic [NUM_LEVELS*OCC_W-1:0]   occ
);

   logic [NUM_LEVELS-1:0] wr_s, rd_s, wr_oor_s, rd_oor_s, ovf_s, unf_s;
   logic [ERR_W-1:0]      err_s;
   logic [2:0]            code_s;
   logic [3:0]            wr_lvl_s, ovf_lvl_s, lvl_s;
   logic [ADDR_W-1:0]     addr_s;

   logic [ERR_W-1:0]      err_pulse_q, err_sticky_q;
   logic [15:0]           err_count_q;
   logic                  first_valid_q;
   logic [2:0]            first_code_q;
   logic [3:0]            first_level_q;
   logic [ADDR_W-1:0]     first_addr_q;

   for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_lvl
      assign wr_s[g] = enable & ram_we & push[g];
      assign rd_s[g] = enable & ram_re & (sel == SEL_W'(g));

      fifo_mon_level #(
         .ADDR_W  (ADDR_W),
         .OCC_W   (OCC_W),
         .LVL_MIN (LEVEL_MIN[g*ADDR_W +: ADDR_W]),
         .LVL_MAX (LEVEL_MAX[g*ADDR_W +: ADDR_W])
      ) u_level (
         .clk_i    (clk),
         .reset_i  (reset),
         .wr_i     (wr_s[g]),
         .rd_i     (rd_s[g]),
         .addra_i  (addra),
         .addrb_i  (addrb),
         .wr_oor_o (wr_oor_s[g]),
         .rd_oor_o (rd_oor_s[g]),
         .ovf_o    (ovf_s[g]),
         .unf_o    (unf_s[g]),
         .occ_o    (occ[g*OCC_W +: OCC_W])
      );
   end

   // Per-code error detection for the current input cycle.
   always_comb begin
      err_s           = {ERR_W{1'b0}};
      err_s[MUTEX]    = enable & ram_we & (|(push & (push - NUM_LEVELS'(1))));
      err_s[WR_RANGE] = |wr_oor_s;
      err_s[RD_RANGE] = |rd_oor_s;
      err_s[RD_SEL]   = enable & ram_re & ({1'b0, sel} >= (SEL_W+1)'(NUM_LEVELS));
      err_s[COLLIDE]  = enable & ram_we & ram_re & (addra == addrb);
      err_s[OVF]      = |ovf_s;
      err_s[UNF]      = |unf_s;
   end

   // Priority encode: lowest error code, lowest level, and the address of the offending side.
   always_comb begin
      code_s    = 3'd0;
      wr_lvl_s  = 4'd0;
      ovf_lvl_s = 4'd0;
      for (int k = ERR_W - 1; k >= 0; k--) begin
         code_s = err_s[k] ? 3'(k) : code_s;
      end
      for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
         wr_lvl_s  = wr_oor_s[i] ? 4'(i) : wr_lvl_s;
         ovf_lvl_s = ovf_s[i]    ? 4'(i) : ovf_lvl_s;
      end
      case (code_s)
         WR_RANGE:               lvl_s = wr_lvl_s;
         OVF:                    lvl_s = ovf_lvl_s;
         RD_RANGE, RD_SEL, UNF:  lvl_s = 4'(sel);
         default:                lvl_s = 4'd0;
      endcase
      case (code_s)
         RD_RANGE, RD_SEL, UNF:  addr_s = addrb;
         default:                addr_s = addra;
      endcase
   end

   // Error pulse, sticky, saturating count and first-error capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_pulse_q   <= {ERR_W{1'b0}};
         err_sticky_q  <= {ERR_W{1'b0}};
         err_count_q   <= 16'd0;
         first_valid_q <= 1'b0;
         first_code_q  <= 3'd0;
         first_level_q <= 4'd0;
         first_addr_q  <= {ADDR_W{1'b0}};
      end else begin
         err_pulse_q <= err_s;
         if (clear) begin
            err_sticky_q  <= {ERR_W{1'b0}};
            err_count_q   <= 16'd0;
            first_valid_q <= 1'b0;
            first_code_q  <= 3'd0;
            first_level_q <= 4'd0;
            first_addr_q  <= {ADDR_W{1'b0}};
         end else begin
            err_sticky_q <= err_sticky_q | err_s;
            if ((|err_s) && (err_count_q != 16'hFFFF)) begin
               err_count_q <= err_count_q + 16'd1;
            end
            if (!first_valid_q && (|err_s)) begin
               first_valid_q <= 1'b1;
               first_code_q  <= code_s;
               first_level_q <= lvl_s;
               first_addr_q  <= addr_s;
            end
         end
      end
   end

   assign err_pulse   = err_pulse_q;
   assign err_sticky  = err_sticky_q;
   assign err_count   = err_count_q;
   assign first_valid = first_valid_q;
   assign first_code  = first_code_q;
   assign first_level = first_level_q;
   assign first_addr  = first_addr_q;

endmodule

// File: tb/tb_fifo_shift_ram_monitor.sv
// Directed self-checking bench for fifo_shift_ram_monitor (default 11-level configuration).
module tb_fifo_shift_ram_monitor;

   logic        clk;
   logic        reset, enable, clear, ram_we, ram_re;
   logic [10:0] push, addra, addrb;
   logic [3:0]  sel;
   logic [6:0]  err_pulse, err_sticky;
   logic [15:0] err_count;
   logic        first_valid;
   logic [2:0]  first_code;
   logic [3:0]  first_level;
   logic [10:0] first_addr;
   logic [87:0] occ;

   int n_chk = 0;
   int n_err = 0;

   fifo_shift_ram_monitor dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .ram_we(ram_we), .ram_re(ram_re), .push(push), .addra(addra),
      .addrb(addrb), .sel(sel), .err_pulse(err_pulse), .err_sticky(err_sticky),
      .err_count(err_count), .first_valid(first_valid), .first_code(first_code),
      .first_level(first_level), .first_addr(first_addr), .occ(occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] occ_of(input int l);
      return occ[l*8 +: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      enable = 1'b1; clear = 1'b0; ram_we = 1'b0; ram_re = 1'b0;
      push = 11'd0; addra = 11'd0; addrb = 11'd0; sel = 4'd0; reset = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (err_pulse !== 7'd0) begin n_err++; $display("FAIL reset_pulse: got %b expected 0", err_pulse); end
      n_chk++; if (err_sticky !== 7'd0) begin n_err++; $display("FAIL reset_sticky: got %b expected 0", err_sticky); end
      n_chk++; if (err_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", err_count); end
      n_chk++; if (first_valid !== 1'b0) begin n_err++; $display("FAIL reset_first_valid: got %b expected 0", first_valid); end
      n_chk++; if (occ !== 88'd0) begin n_err++; $display("FAIL reset_occ: got %h expected 0", occ); end
   endtask

   task automatic test_overflow();
      int bad = 0;
      for (int a = 0; a <= 16; a++) begin
         ram_we = 1'b1; push = 11'd1; addra = 11'(a);
         tick();
         if (err_pulse !== 7'd0) bad++;
      end
      ram_we = 1'b0; push = 11'd0;
      n_chk++; if (bad !== 0) begin n_err++; $display("FAIL fill_no_err: got %0d erroring cycles expected 0", bad); end
      n_chk++; if (occ_of(0) !== 8'd17) begin n_err++; $display("FAIL fill_occ0: got %0d expected 17", occ_of(0)); end
      ram_we = 1'b1; push = 11'd1; addra = 11'd5;
      tick();
      idle();
      n_chk++; if (err_pulse !== 7'b0100000) begin n_err++; $display("FAIL ovf_pulse: got %b expected 0100000", err_pulse); end
      n_chk++; if (occ_of(0) !== 8'd17) begin n_err++; $display("FAIL ovf_occ0_hold: got %0d expected 17", occ_of(0)); end
      n_chk++; if (first_code !== 3'd5) begin n_err++; $display("FAIL ovf_first_code: got %0d expected 5", first_code); end
      n_chk++; if (first_level !== 4'd0) begin n_err++; $display("FAIL ovf_first_level: got %0d expected 0", first_level); end
      n_chk++; if (first_addr !== 11'd5) begin n_err++; $display("FAIL ovf_first_addr: got %0d expected 5", first_addr); end
      n_chk++; if (err_count !== 16'd1) begin n_err++; $display("FAIL ovf_count: got %0d expected 1", err_count); end
      tick();
      n_chk++; if (err_pulse !== 7'd0) begin n_err++; $display("FAIL ovf_pulse_drop: got %b expected 0", err_pulse); end
      n_chk++; if (err_sticky !== 7'b0100000) begin n_err++; $display("FAIL ovf_sticky: got %b expected 0100000", err_sticky); end
   endtask

   task automatic test_wr_range();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      ram_we = 1'b1; push = 11'd2; addra = 11'd98;
      tick();
      n_chk++; if (err_pulse !== 7'b0000010) begin n_err++; $display("FAIL wr_oor_pulse: got %b expected 0000010", err_pulse); end
      n_chk++; if (first_code !== 3'd1) begin n_err++; $display("FAIL wr_oor_code: got %0d expected 1", first_code); end
      n_chk++; if (first_level !== 4'd1) begin n_err++; $display("FAIL wr_oor_level: got %0d expected 1", first_level); end
      n_chk++; if (first_addr !== 11'd98) begin n_err++; $display("FAIL wr_oor_addr: got %0d expected 98", first_addr); end
      addra = 11'd97;
      tick();
      idle();
      n_chk++; if (err_pulse !== 7'd0) begin n_err++; $display("FAIL wr_edge_ok: got %b expected 0", err_pulse); end
      n_chk++; if (occ_of(1) !== 8'd2) begin n_err++; $display("FAIL wr_occ1: got %0d expected 2", occ_of(1)); end
   endtask

   task automatic test_mutex();
      do_reset();
      ram_we = 1'b1; push = 11'b00000000011; addra = 11'd10;
      tick();
      idle();
      n_chk++; if (err_pulse !== 7'b0000011) begin n_err++; $display("FAIL mutex_pulse: got %b expected 0000011", err_pulse); end
      n_chk++; if (err_count !== 16'd1) begin n_err++; $display("FAIL mutex_count: got %0d expected 1", err_count); end
      n_chk++; if (first_code !== 3'd0) begin n_err++; $display("FAIL mutex_code: got %0d expected 0", first_code); end
      n_chk++; if (occ_of(0) !== 8'd1 || occ_of(1) !== 8'd1) begin n_err++; $display("FAIL mutex_occ: got %0d/%0d expected 1/1", occ_of(0), occ_of(1)); end
   endtask

   task automatic test_read();
      do_reset();
      ram_re = 1'b1; sel = 4'd11; addrb = 11'd0;
      tick();
      n_chk++; if (err_pulse !== 7'b0001000) begin n_err++; $display("FAIL rd_sel_pulse: got %b expected 0001000", err_pulse); end
      sel = 4'd2; addrb = 11'd128;
      tick();
      idle();
      n_chk++; if (err_pulse !== 7'b1000000) begin n_err++; $display("FAIL unf_pulse: got %b expected 1000000", err_pulse); end
      n_chk++; if (occ_of(2) !== 8'd0) begin n_err++; $display("FAIL unf_occ2: got %0d expected 0", occ_of(2)); end
      n_chk++; if (first_code !== 3'd3) begin n_err++; $display("FAIL first_held: got %0d expected 3", first_code); end
      n_chk++; if (err_count !== 16'd2) begin n_err++; $display("FAIL rd_count: got %0d expected 2", err_count); end
   endtask

   task automatic test_collide_clear();
      for (int a = 256; a < 260; a++) begin
         ram_we = 1'b1; push = 11'd8; addra = 11'(a);
         tick();
      end
      ram_we = 1'b1; push = 11'd8; addra = 11'd300;
      ram_re = 1'b1; sel = 4'd3; addrb = 11'd300;
      tick();
      idle();
      n_chk++; if (err_pulse !== 7'b0010000) begin n_err++; $display("FAIL collide_pulse: got %b expected 0010000", err_pulse); end
      n_chk++; if (occ_of(3) !== 8'd4) begin n_err++; $display("FAIL collide_occ3: got %0d expected 4", occ_of(3)); end
      n_chk++; if (err_sticky !== 7'b1011000) begin n_err++; $display("FAIL collide_sticky: got %b expected 1011000", err_sticky); end
      clear = 1'b1;
      tick();
      n_chk++; if (err_sticky !== 7'd0 || first_valid !== 1'b0 || err_count !== 16'd0) begin
         n_err++; $display("FAIL clear_state: got sticky=%b fv=%b cnt=%0d expected 0/0/0", err_sticky, first_valid, err_count); end
      n_chk++; if (occ_of(3) !== 8'd4) begin n_err++; $display("FAIL clear_occ3: got %0d expected 4", occ_of(3)); end
      ram_re = 1'b1; sel = 4'd12;
      tick();
      idle();
      n_chk++; if (err_pulse !== 7'b0001000) begin n_err++; $display("FAIL clear_err_pulse: got %b expected 0001000", err_pulse); end
      n_chk++; if (err_sticky !== 7'd0 || err_count !== 16'd0) begin n_err++; $display("FAIL clear_wins: got sticky=%b cnt=%0d expected 0/0", err_sticky, err_count); end
   endtask

   task automatic test_enable_reset();
      enable = 1'b0;
      ram_we = 1'b1; push = 11'b00000000011; addra = 11'd2000;
      ram_re = 1'b1; sel = 4'd15; addrb = 11'd2000;
      tick();
      idle();
      n_chk++; if (err_pulse !== 7'd0) begin n_err++; $display("FAIL disabled_pulse: got %b expected 0", err_pulse); end
      n_chk++; if (occ_of(0) !== 8'd0 || occ_of(3) !== 8'd4) begin n_err++; $display("FAIL disabled_occ: got %0d/%0d expected 0/4", occ_of(0), occ_of(3)); end
      do_reset();
      n_chk++; if (occ !== 88'd0) begin n_err++; $display("FAIL midreset_occ: got %h expected 0", occ); end
      n_chk++; if (err_pulse !== 7'd0 || err_sticky !== 7'd0 || err_count !== 16'd0 || first_valid !== 1'b0) begin
         n_err++; $display("FAIL midreset_err: got p=%b s=%b c=%0d fv=%b expected zeros", err_pulse, err_sticky, err_count, first_valid); end
   endtask

   initial begin
      idle();
      test_reset();
      test_overflow();
      test_wr_range();
      test_mutex();
      test_read();
      test_collide_clear();
      test_enable_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
